// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage core.
// Resolves load-use hazards, multi-cycle divide stalls, external holds and EX-stage
// jumps into PC / IF/ID / ID/EX hold and flush controls, and counts stall and flush cycles.
module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                      ex_is_load_i,
  input  logic                      ex_jump_i,
  input  logic [ADDR_WIDTH-1:0]     ex_jump_addr_i,
  input  logic                      ex_div_start_i,
  input  logic                      div_done_i,
  input  logic                      hold_req_i,
  output logic                      stall_pc_o,
  output logic                      stall_if_id_o,
  output logic                      stall_id_ex_o,
  output logic                      flush_if_id_o,
  output logic                      flush_id_ex_o,
  output logic                      jump_o,
  output logic [ADDR_WIDTH-1:0]     jump_addr_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  // The jump cycle itself is the first flush cycle; FLUSH covers the remaining ones.
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [FW-1:0]        fcnt;
  logic [FW-1:0]        fcnt_nxt;
  logic                 jump_q;
  logic                 load_use;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  // Load-use hazard: a load in EX writes a non-zero register that the ID instruction reads.
  always_comb begin
    load_use = ex_is_load_i && (ex_rd_addr_i != '0) &&
               ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
  end

  // Next-state and control outputs; reset forces every control low, a flush never coexists with a stall.
  always_comb begin
    state_nxt     = state;
    fcnt_nxt      = fcnt;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_o        = 1'b0;
    jump_addr_o   = '0;
    if (!rst) begin
      case (state)
        RUN: begin
          // jump_q blocks back-to-back redirects when there is no FLUSH window (FLUSH_CYCLES=1)
          if (ex_jump_i && !jump_q) begin
            jump_o        = 1'b1;
            jump_addr_o   = ex_jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FLOAD;
            end
          end else if (ex_div_start_i) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            stall_id_ex_o = 1'b1;
            state_nxt     = DIV_WAIT;
          end else if (load_use) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (hold_req_i) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            stall_id_ex_o = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (div_done_i) begin
            state_nxt = RUN;
          end else begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            stall_id_ex_o = 1'b1;
          end
        end
        FLUSH: begin
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (fcnt <= FW'(1)) begin
            state_nxt = RUN;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt - FW'(1);
          end
        end
        default: begin
          state_nxt = RUN;
          fcnt_nxt  = '0;
        end
      endcase
    end
  end

  // State register, previous-jump flag and the wrapping stall/flush performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      fcnt      <= '0;
      jump_q    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      fcnt   <= fcnt_nxt;
      jump_q <= jump_o;
      if (stall_pc_o) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (flush_id_ex_o) begin
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Counter outputs read as zero while reset is held, like every other output.
  always_comb begin
    stall_cnt_o = rst ? '0 : stall_cnt;
    flush_cnt_o = rst ? '0 : flush_cnt;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (FLUSH_CYCLES=1 and 3) share
// the stimulus; the driver queues hand-computed expectations and a negedge monitor checks them.
module tb_pipeline_hazard_ctrl;

  // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, jump}
  typedef logic [5:0] ctrl_t;
  localparam ctrl_t NONE   = 6'b000000;
  localparam ctrl_t STALL3 = 6'b111000;
  localparam ctrl_t LU     = 6'b110010;
  localparam ctrl_t JMP    = 6'b000111;
  localparam ctrl_t FL     = 6'b000110;

  typedef struct {
    int          idx;
    ctrl_t       e1;
    ctrl_t       e3;
    logic [31:0] addr;
    bit          chk;
    logic [31:0] sc1;
    logic [31:0] fl1;
    logic [31:0] sc3;
    logic [31:0] fl3;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit          cnt_pending = 0;
  logic [31:0] p_sc1, p_fl1, p_sc3, p_fl3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_jump;
  logic [31:0] ex_jump_addr;
  logic        ex_div_start, div_done, hold_req;

  logic        a_spc, a_sif, a_sie, a_fif, a_fie, a_jmp;
  logic [31:0] a_addr, a_sc, a_fc;
  logic        b_spc, b_sif, b_sie, b_fif, b_fie, b_jmp;
  logic [31:0] b_addr, b_sc, b_fc;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .FLUSH_CYCLES(1), .CNT_WIDTH(32)) u_fc1 (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_rd_addr_i(ex_rd_addr), .ex_is_load_i(ex_is_load),
    .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_jump_addr),
    .ex_div_start_i(ex_div_start), .div_done_i(div_done), .hold_req_i(hold_req),
    .stall_pc_o(a_spc), .stall_if_id_o(a_sif), .stall_id_ex_o(a_sie),
    .flush_if_id_o(a_fif), .flush_id_ex_o(a_fie), .jump_o(a_jmp), .jump_addr_o(a_addr),
    .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
  );

  pipeline_hazard_ctrl #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .FLUSH_CYCLES(3), .CNT_WIDTH(32)) u_fc3 (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_rd_addr_i(ex_rd_addr), .ex_is_load_i(ex_is_load),
    .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_jump_addr),
    .ex_div_start_i(ex_div_start), .div_done_i(div_done), .hold_req_i(hold_req),
    .stall_pc_o(b_spc), .stall_if_id_o(b_sif), .stall_id_ex_o(b_sie),
    .flush_if_id_o(b_fif), .flush_id_ex_o(b_fie), .jump_o(b_jmp), .jump_addr_o(b_addr),
    .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
  );

  // One comparison: bump the counters and report any difference.
  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic clearInputs();
    id_rs1_addr  = '0;
    id_rs2_addr  = '0;
    id_rs1_used  = 1'b0;
    id_rs2_used  = 1'b0;
    ex_rd_addr   = '0;
    ex_is_load   = 1'b0;
    ex_jump      = 1'b0;
    ex_jump_addr = '0;
    ex_div_start = 1'b0;
    div_done     = 1'b0;
    hold_req     = 1'b0;
  endtask

  task automatic loadUse(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
    ex_is_load  = 1'b1;
    ex_rd_addr  = rd;
    id_rs1_addr = rs1;
    id_rs1_used = u1;
    id_rs2_addr = rs2;
    id_rs2_used = u2;
  endtask

  // Arms a counter check for the next cycle queued by applyStimulus.
  task automatic expectCounts(input logic [31:0] sc1, input logic [31:0] fl1,
                              input logic [31:0] sc3, input logic [31:0] fl3);
    cnt_pending = 1;
    p_sc1 = sc1;
    p_fl1 = fl1;
    p_sc3 = sc3;
    p_fl3 = fl3;
  endtask

  // Queues the expectation for the inputs now applied, then advances one clock.
  task automatic applyStimulus(input ctrl_t e1, input ctrl_t e3, input logic [31:0] a);
    exp_t e;
    e.idx  = cyc;
    e.e1   = e1;
    e.e3   = e3;
    e.addr = a;
    e.chk  = cnt_pending;
    e.sc1  = p_sc1;
    e.fl1  = p_fl1;
    e.sc3  = p_sc3;
    e.fl3  = p_fl3;
    sb.push_back(e);
    cnt_pending = 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so each negedge retires one queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput($sformatf("c%0d ctrl fc1", e.idx), {26'd0, a_spc, a_sif, a_sie, a_fif, a_fie, a_jmp}, {26'd0, e.e1});
      checkOutput($sformatf("c%0d ctrl fc3", e.idx), {26'd0, b_spc, b_sif, b_sie, b_fif, b_fie, b_jmp}, {26'd0, e.e3});
      checkOutput($sformatf("c%0d addr fc1", e.idx), a_addr, e.e1[0] ? e.addr : 32'd0);
      checkOutput($sformatf("c%0d addr fc3", e.idx), b_addr, e.e3[0] ? e.addr : 32'd0);
      if (e.chk) begin
        checkOutput($sformatf("c%0d stall_cnt fc1", e.idx), a_sc, e.sc1);
        checkOutput($sformatf("c%0d flush_cnt fc1", e.idx), a_fc, e.fl1);
        checkOutput($sformatf("c%0d stall_cnt fc3", e.idx), b_sc, e.sc3);
        checkOutput($sformatf("c%0d flush_cnt fc3", e.idx), b_fc, e.fl3);
      end
    end
  end

  // Watchdog so the run always ends even if the driver stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    rst = 1'b1;
    clearInputs();
    @(posedge clk);
    #1;

    // reset forces all outputs low even with requests present
    ex_jump = 1'b1; ex_jump_addr = 32'h44; hold_req = 1'b1;
    expectCounts(0, 0, 0, 0);
    applyStimulus(NONE, NONE, 32'h0);
    rst = 1'b0; clearInputs();
    expectCounts(0, 0, 0, 0);
    applyStimulus(NONE, NONE, 32'h0);

    // load-use on rs1, rd=0 suppressed, rs2 match, unused operand
    clearInputs(); loadUse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    expectCounts(0, 0, 0, 0);
    applyStimulus(LU, LU, 32'h0);
    clearInputs(); loadUse(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    applyStimulus(NONE, NONE, 32'h0);
    clearInputs(); loadUse(5'd7, 5'd7, 1'b0, 5'd7, 1'b1);
    applyStimulus(LU, LU, 32'h0);
    clearInputs(); loadUse(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
    expectCounts(2, 2, 2, 2);
    applyStimulus(NONE, NONE, 32'h0);
    clearInputs(); ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_rs1_used = 1'b1;
    applyStimulus(NONE, NONE, 32'h0);

    // jump beats a simultaneous load-use; fc3 holds flush, fc1 resumes
    clearInputs(); loadUse(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    ex_jump = 1'b1; ex_jump_addr = 32'h80;
    applyStimulus(JMP, JMP, 32'h80);
    clearInputs();
    applyStimulus(NONE, FL, 32'h0);
    clearInputs(); loadUse(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    applyStimulus(LU, FL, 32'h0);
    clearInputs();
    expectCounts(3, 4, 2, 5);
    applyStimulus(NONE, NONE, 32'h0);

    // jump followed one cycle later by a second jump, which is ignored
    clearInputs(); ex_jump = 1'b1; ex_jump_addr = 32'h100;
    applyStimulus(JMP, JMP, 32'h100);
    clearInputs(); ex_jump = 1'b1; ex_jump_addr = 32'h200;
    applyStimulus(NONE, FL, 32'h0);
    clearInputs();
    applyStimulus(NONE, FL, 32'h0);
    clearInputs();
    expectCounts(3, 5, 2, 8);
    applyStimulus(NONE, NONE, 32'h0);

    // divide: start cycle + 32 wait cycles stalled, done cycle free
    clearInputs(); ex_div_start = 1'b1;
    applyStimulus(STALL3, STALL3, 32'h0);
    for (int i = 1; i <= 32; i++) begin
      clearInputs();
      if (i == 5) begin
        ex_jump = 1'b1; ex_jump_addr = 32'h300;
        loadUse(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      end
      if (i == 10) hold_req = 1'b1;
      applyStimulus(STALL3, STALL3, 32'h0);
    end
    clearInputs(); div_done = 1'b1; ex_div_start = 1'b1;
    applyStimulus(NONE, NONE, 32'h0);
    clearInputs();
    expectCounts(36, 5, 35, 8);
    applyStimulus(NONE, NONE, 32'h0);

    // external hold for 4 cycles
    for (int i = 0; i < 4; i++) begin
      clearInputs(); hold_req = 1'b1;
      applyStimulus(STALL3, STALL3, 32'h0);
    end
    clearInputs();
    expectCounts(40, 5, 39, 8);
    applyStimulus(NONE, NONE, 32'h0);

    // reset during DIV_WAIT
    clearInputs(); ex_div_start = 1'b1;
    applyStimulus(STALL3, STALL3, 32'h0);
    clearInputs();
    applyStimulus(STALL3, STALL3, 32'h0);
    rst = 1'b1; clearInputs(); hold_req = 1'b1;
    expectCounts(0, 0, 0, 0);
    applyStimulus(NONE, NONE, 32'h0);
    rst = 1'b0; clearInputs();
    expectCounts(0, 0, 0, 0);
    applyStimulus(NONE, NONE, 32'h0);

    // reset during FLUSH
    clearInputs(); ex_jump = 1'b1; ex_jump_addr = 32'h40;
    applyStimulus(JMP, JMP, 32'h40);
    rst = 1'b1; clearInputs();
    expectCounts(0, 0, 0, 0);
    applyStimulus(NONE, NONE, 32'h0);
    rst = 1'b0; clearInputs();
    expectCounts(0, 0, 0, 0);
    applyStimulus(NONE, NONE, 32'h0);
    clearInputs(); loadUse(5'd12, 5'd0, 1'b0, 5'd12, 1'b1);
    applyStimulus(LU, LU, 32'h0);
    clearInputs();
    expectCounts(1, 1, 1, 1);
    applyStimulus(NONE, NONE, 32'h0);

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
